alap_job_ctrl: RTL and testbench
================================

# alap_job_ctrl

Job sequencer sitting directly upstream of the ALAP control unit and its datapath. Accepts operand pairs over a valid/ready stream, buffers them in a small FIFO, launches one computation at a time by pulsing `go` while holding the operands on the datapath input buses, and captures the datapath result in the cycle the control unit asserts `done`. Results leave through a single-entry valid/ready output buffer.

## Interface
- `WIDTH`, 32, operand/result width (matches datapath).
- `DEPTH`, 4, operand FIFO depth; power of two, ≥2.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  operand pair valid.
- `s_ready`  out  1  FIFO can accept (= not full).
- `s_a`, `s_b`  in  WIDTH each  operand pair.
- `go`  out  1  launch pulse to control unit.
- `in0`, `in1`  out  WIDTH each  operands to datapath input buses.
- `done`  in  1  control unit completion (one cycle, final state).
- `result`  in  WIDTH  datapath result bus, valid while `done`=1.
- `m_valid`  out  1  result available.
- `m_ready`  in  1  consumer accepts result.
- `m_result`  out  WIDTH  captured result.
- `busy`  out  1  job in flight (state ≠ IDLE).
- `done_err`  out  1  sticky: `done` seen outside RUN.

## Operation
- Push: `s_valid && s_ready` writes {s_a,s_b} at tail. Push and pop in the same cycle are both honoured; count unchanged.
- FSM states IDLE, LAUNCH, RUN:
  - IDLE → LAUNCH when FIFO non-empty and output slot free (`!m_valid || m_ready`). On that edge pop head into operand hold regs `op_a/op_b` and set registered `go`.
  - LAUNCH: `go`=1 (control unit is in its idle state and latches `in0/in1` this edge). → RUN unconditionally; `go` clears.
  - RUN: wait for `done`. On `done`: `m_result` ← `result`, `m_valid` ← 1, → IDLE.
- `in0/in1` driven from `op_a/op_b` at all times; hold regs change only on pop, so operands remain stable through the control unit's capture edge and the whole job.
- Output slot: `m_valid` clears on `m_valid && m_ready` unless a new capture occurs the same edge (capture wins, `m_valid` stays 1). A capture can never overwrite an unread result: launch requires the slot free, and one job is in flight at most.
- `done` in IDLE or LAUNCH: ignored for capture, sets `done_err` (cleared only by reset).

## Timing
- Reset values: `go`=0, `m_valid`=0, `m_result`=0, `in0`=`in1`=0, `busy`=0, `done_err`=0, FIFO empty (`s_ready`=1), state IDLE.
- Reset mid-job: everything returns to reset values immediately; the control unit shares `rst`, so both restart together; the in-flight job and FIFO contents are discarded.
- Control unit latency: `done` asserted 8 cycles after the `go` cycle.
- Empty system, push accepted at edge E0: LAUNCH (`go`=1) in cycle 2, `done` in cycle 10, `m_valid` in cycle 11.
- Back-to-back jobs with `m_ready`=1: one launch every 10 cycles.
- `s_ready` depends only on FIFO count (no combinational path from `s_valid`); `m_valid` and `go` are registered.

## Structure
- Shared package `alap_pkg`: FSM state enum (IDLE/LAUNCH/RUN), `ALAP_DONE_LAT = 8` constant.
- One sub-module: `alap_op_fifo`, a synchronous FIFO (width 2·WIDTH, depth DEPTH, pointer-plus-count, full/empty flags). The FSM, hold registers, and output slot live in the top.

## Test plan
- Single job: push a=3, b=5 at cycle 0; model `done` 8 cycles after `go`, returning `result`=0x20 → `go` in cycle 2, `in0`=3 and `in1`=5 stable cycles 2–10, `m_valid` in cycle 11 with `m_result`=0x20.
- Fill: push 5 pairs back-to-back, `m_ready`=1 → `s_ready` low after 4 held entries (first popped at launch, so 5th accepted one cycle later); launches spaced 10 cycles apart; results in push order.
- Backpressure: `m_ready`=0 after first result → no second `go` until `m_ready` pulses; relaunch the cycle after the drain edge.
- Simultaneous drain and capture: `m_ready`=1 exactly in the `done` cycle with prior result pending → impossible by construction; assert `m_valid` never rises while already set without a handshake.
- Spurious `done` in IDLE → `done_err`=1, `m_valid` unchanged, persists until `rst`.
- Reset asserted in RUN cycle 5 → all outputs at reset values in the same cycle; FIFO empty; a new push after release completes normally.

Source files
------------

// File: rtl/alap_pkg.sv
// Shared definitions for the ALAP job sequencer: FSM states and the
// control-unit completion latency.
package alap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN
  } state_e;

  // Cycles from the go cycle to the control unit's done cycle.
  localparam int ALAP_DONE_LAT = 8;

endpackage

// File: rtl/alap_op_fifo.sv
// Synchronous operand FIFO: circular buffer with read/write pointers and an
// occupancy count. Writes are dropped when full, reads ignored when empty.
module alap_op_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write.
  // NOTE: the array is not reset; empty/full come from count_q, so stale
  // contents are never observed and the memory can map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alap_job_ctrl.sv
// Job sequencer in front of the ALAP control unit: buffers operand pairs,
// launches one job at a time with a registered go pulse, holds the operands
// on in0/in1 for the whole job and captures the result on done into a
// single-entry output slot.
module alap_job_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_a,
  input  logic [WIDTH-1:0] s_b,
  output logic             go,
  output logic [WIDTH-1:0] in0,
  output logic [WIDTH-1:0] in1,
  input  logic             done,
  input  logic [WIDTH-1:0] result,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_result,
  output logic             busy,
  output logic             done_err
);

  import alap_pkg::*;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [WIDTH-1:0]   m_result_q, m_result_d;
  logic               go_q, go_d;
  logic               m_valid_q, m_valid_d;
  logic               done_err_q, done_err_d;
  logic               pop;
  logic               fifo_full, fifo_empty;
  logic [2*WIDTH-1:0] fifo_rdata;

  alap_op_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s_valid),
    .pop_i   (pop),
    .wdata_i ({s_a, s_b}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign s_ready  = !fifo_full;
  assign go       = go_q;
  assign in0      = op_a_q;
  assign in1      = op_b_q;
  assign m_valid  = m_valid_q;
  assign m_result = m_result_q;
  assign busy     = (state_q != ST_IDLE);
  assign done_err = done_err_q;

  // Next-state, launch and capture decisions.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d    = state_q;
    go_d       = 1'b0;
    pop        = 1'b0;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    m_valid_d  = m_valid_q;
    m_result_d = m_result_q;
    done_err_d = done_err_q;

    // Slot drains on handshake; a capture below overrides this.
    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (done) done_err_d = 1'b1;
        // Launch only when the slot will be free, so a capture never
        // overwrites an unread result.
        if (!fifo_empty && (!m_valid_q || m_ready)) begin
          pop              = 1'b1;
          {op_a_d, op_b_d} = fifo_rdata;
          go_d             = 1'b1;
          state_d          = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (done) done_err_d = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (done) begin
          m_result_d = result;
          m_valid_d  = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand hold, output slot and error flag registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      go_q       <= 1'b0;
      m_valid_q  <= 1'b0;
      m_result_q <= '0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      go_q       <= go_d;
      m_valid_q  <= m_valid_d;
      m_result_q <= m_result_d;
      done_err_q <= done_err_d;
    end
  end

endmodule

// File: tb/tb_alap_job_ctrl.sv
// Self-checking bench for alap_job_ctrl: a control-unit stub returns
// (a+b)<<2 eight cycles after go, a transaction-level model predicts every
// output each cycle, and directed sequences pin the model with literals.
module tb_alap_job_ctrl;

  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_valid = 1'b0, m_ready = 1'b0, force_done = 1'b0;
  logic [W-1:0] s_a = '0, s_b = '0;
  logic         s_ready, go, done, m_valid, busy, done_err;
  logic [W-1:0] in0, in1, result, m_result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  alap_job_ctrl #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_a      (s_a),
    .s_b      (s_b),
    .go       (go),
    .in0      (in0),
    .in1      (in1),
    .done     (done),
    .result   (result),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_result (m_result),
    .busy     (busy),
    .done_err (done_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Control-unit stub: latches in0/in1 at the go edge, pulses done in the
  // eighth cycle after the go cycle with result (a+b)<<2.
  int   cu_cnt;
  logic stub_done;
  assign done = stub_done | force_done;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cu_cnt    <= 0;
      stub_done <= 1'b0;
      result    <= '0;
    end else if (go) begin
      cu_cnt    <= 7;
      stub_done <= 1'b0;
      result    <= (in0 + in1) << 2;
    end else if (cu_cnt > 0) begin
      cu_cnt    <= cu_cnt - 1;
      stub_done <= (cu_cnt == 1);
    end else begin
      stub_done <= 1'b0;
    end
  end

  // Transaction-level model: queue of pending pairs, a job timer counting
  // cycles since launch (0 = none), and the output slot.
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; } pair_t;
  pair_t        mq[$];
  int           job_t;
  logic [W-1:0] cur_a, cur_b, slot_d;
  logic         slot_v, err;

  task automatic model_step();
    bit    push, launch, capture;
    pair_t p;
    push    = s_valid && (mq.size() < DEPTH);
    launch  = (job_t == 0) && (mq.size() > 0) && (!slot_v || m_ready);
    capture = (job_t >= 2) && done;
    if (done && job_t < 2) err = 1'b1;
    if (slot_v && m_ready) slot_v = 1'b0;
    if (capture) begin
      slot_v = 1'b1;
      slot_d = result;
      job_t  = 0;
    end else if (job_t != 0) begin
      job_t++;
    end
    if (launch) begin
      p     = mq.pop_front();
      cur_a = p.a;
      cur_b = p.b;
      job_t = 1;
    end
    if (push) begin
      p.a = s_a;
      p.b = s_b;
      mq.push_back(p);
    end
  endtask

  // Model update on the same edges as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      job_t  = 0;
      cur_a  = '0;
      cur_b  = '0;
      slot_v = 1'b0;
      slot_d = '0;
      err    = 1'b0;
    end else begin
      model_step();
    end
  end

  // Compare process on the falling edge plus launch/result logging.
  int           go_times[$];
  logic [W-1:0] out_q[$];
  logic         prev_mv = 1'b0, prev_mr = 1'b0;
  logic [W-1:0] prev_res = '0;
  always @(negedge clk) begin
    check("s_ready",  s_ready,  mq.size() < DEPTH);
    check("go",       go,       job_t == 1);
    check("busy",     busy,     job_t != 0);
    check("in0",      in0,      cur_a);
    check("in1",      in1,      cur_b);
    check("m_valid",  m_valid,  slot_v);
    check("m_result", m_result, slot_d);
    check("done_err", done_err, err);
    if (prev_mv && !prev_mr && !rst) begin
      check("slot_held_valid",  m_valid,  1'b1);
      check("slot_held_result", m_result, prev_res);
    end
    if (!rst && go) go_times.push_back(cyc);
    if (!rst && m_valid && m_ready) out_q.push_back(m_result);
    prev_mv  = rst ? 1'b0 : m_valid;
    prev_mr  = m_ready;
    prev_res = m_result;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    int  k = 0;
    bit  acc;
    s_valid = 1'b1;
    s_a     = a;
    s_b     = b;
    do begin
      acc = s_ready;
      tick();
      k++;
    end while (!acc && k < 50);
    s_valid = 1'b0;
    check("push_accept_bound", acc, 1'b1);
  endtask

  task automatic wait_outs(input int n);
    int k = 0;
    while (out_q.size() < n && k < 200) begin
      tick();
      k++;
    end
    check("result_count_bound", out_q.size(), n);
  endtask

  task automatic wait_negedge_go();
    int k = 0;
    @(negedge clk);
    while (!go && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("go_seen_bound", go, 1'b1);
  endtask

  logic [W-1:0] fill_exp [5];

  initial begin
    fill_exp[0] = 32'd12;
    fill_exp[1] = 32'd120;
    fill_exp[2] = 32'd56;
    fill_exp[3] = 32'hFFFF_FFFC;
    fill_exp[4] = 32'd1200;

    // Reset state.
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_go", go, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in0", in0, 0);
    check("rst_m_result", m_result, 0);
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    tick();

    // Single job: push in cycle 0, go in cycle 2, m_valid in cycle 11.
    push_pair(32'd3, 32'd5);
    @(negedge clk);
    check("single_go_c1", go, 1'b0);
    tick();
    @(negedge clk);
    check("single_go_c2", go, 1'b1);
    check("single_in0_c2", in0, 32'd3);
    check("single_in1_c2", in1, 32'd5);
    for (int c = 3; c <= 10; c++) begin
      tick();
      @(negedge clk);
      check("single_in0_hold", in0, 32'd3);
      check("single_in1_hold", in1, 32'd5);
      check("single_mvalid_low", m_valid, 1'b0);
    end
    check("single_busy_c10", busy, 1'b1);
    tick();
    @(negedge clk);
    check("single_mvalid_c11", m_valid, 1'b1);
    check("single_mresult_c11", m_result, 32'h20);
    check("single_busy_c11", busy, 1'b0);
    repeat (3) tick();

    // Fill: five back-to-back pushes, all accepted; FIFO full afterwards.
    go_times.delete();
    out_q.delete();
    push_pair(32'd1, 32'd2);
    push_pair(32'd10, 32'd20);
    push_pair(32'd7, 32'd7);
    push_pair(32'd0, 32'hFFFF_FFFF);
    push_pair(32'd100, 32'd200);
    @(negedge clk);
    check("fill_s_ready_full", s_ready, 1'b0);
    wait_outs(5);
    for (int i = 0; i < 5; i++) check("fill_order", out_q[i], fill_exp[i]);
    check("fill_launch_count", go_times.size(), 5);
    for (int i = 0; i + 1 < go_times.size(); i++)
      check("fill_launch_spacing", go_times[i+1] - go_times[i], 10);
    repeat (3) tick();

    // Backpressure with a spurious done while a result waits in the slot.
    m_ready = 1'b0;
    out_q.delete();
    push_pair(32'd2, 32'd2);
    push_pair(32'd4, 32'd4);
    begin
      int k = 0;
      while (!m_valid && k < 50) begin
        tick();
        k++;
      end
      check("bp_mvalid_bound", m_valid, 1'b1);
    end
    go_times.delete();
    repeat (5) tick();
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    @(negedge clk);
    check("spurious_done_err", done_err, 1'b1);
    check("spurious_mvalid", m_valid, 1'b1);
    check("spurious_mresult", m_result, 32'd16);
    repeat (8) tick();
    check("bp_no_launch", go_times.size(), 0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    @(negedge clk);
    check("bp_relaunch_go", go, 1'b1);
    check("bp_drained", m_valid, 1'b0);
    m_ready = 1'b1;
    wait_outs(2);
    check("bp_second_result", out_q[1], 32'd32);
    check("err_sticky", done_err, 1'b1);
    repeat (3) tick();

    // Reset in the fifth RUN cycle with more jobs queued.
    push_pair(32'd9, 32'd9);
    push_pair(32'd5, 32'd6);
    push_pair(32'd1, 32'd1);
    wait_negedge_go();
    repeat (5) tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_go", go, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_m_valid", m_valid, 1'b0);
    check("midrst_in0", in0, 0);
    check("midrst_err", done_err, 1'b0);
    check("midrst_s_ready", s_ready, 1'b1);
    tick();
    rst = 1'b0;
    go_times.delete();
    out_q.delete();
    repeat (12) tick();
    check("midrst_fifo_empty", go_times.size(), 0);
    push_pair(32'd6, 32'd7);
    wait_outs(1);
    check("after_rst_result", out_q[0], 32'd52);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
